// File: rtl/pong_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_pkg                                                                 |
// | Shared types and default geometry for the Pong game-state engine.        |
// |   game_state_t : IDLE / SERVE / PLAY / OVER encoding (2 bits)            |
// |   DEF_*        : default geometry, speeds and timing                     |
// |   centre()     : top-left coordinate that centres an object on a span   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int DEF_H_RES         = 640;
  localparam int DEF_V_RES         = 480;
  localparam int DEF_BALL_SIZE     = 8;
  localparam int DEF_PADDLE_W      = 8;
  localparam int DEF_PADDLE_H      = 64;
  localparam int DEF_PADDLE_MARGIN = 16;
  localparam int DEF_PADDLE_SPEED  = 4;
  localparam int DEF_BALL_SPEED    = 2;
  localparam int DEF_SCORE_W       = 4;
  localparam int DEF_WIN_SCORE     = 9;
  localparam int DEF_SERVE_FRAMES  = 60;

  function automatic int centre(input int span, input int size);
    return (span - size) / 2;
  endfunction

  // Derived defaults: ball centre, paddle rest y, paddle x columns.
  localparam int DEF_BALL_X0 = centre(DEF_H_RES, DEF_BALL_SIZE);
  localparam int DEF_BALL_Y0 = centre(DEF_V_RES, DEF_BALL_SIZE);
  localparam int DEF_PDL_Y0  = centre(DEF_V_RES, DEF_PADDLE_H);
  localparam int DEF_P1_X    = DEF_PADDLE_MARGIN;
  localparam int DEF_P2_X    = DEF_H_RES - DEF_PADDLE_MARGIN - DEF_PADDLE_W;

endpackage
`default_nettype wire

// File: rtl/pong_paddle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_paddle                                                              |
// | One paddle's vertical position register with up/down stepping and       |
// | clamping to [0, V_RES-PADDLE_H].                                         |
// | Ports: clk_0, rst (async, active-high), step (advance one frame),        |
// |        up, down (button levels), ypos (top edge of the paddle).          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pong_paddle
  import pong_pkg::*;
#(
  parameter int V_RES        = DEF_V_RES,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int PADDLE_SPEED = DEF_PADDLE_SPEED
)(
  input  logic       clk_0,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       down,
  output logic [9:0] ypos
);

  localparam logic signed [10:0] Y_MAX = 11'(V_RES - PADDLE_H);
  localparam logic signed [10:0] SPEED = 11'(PADDLE_SPEED);
  localparam logic [9:0]         Y_RST = 10'(centre(V_RES, PADDLE_H));

  logic signed [10:0] y_cur;
  logic signed [10:0] y_next;

  // One extra signed bit lets an upward step go negative before clamping.
  always_comb begin
    y_cur  = signed'({1'b0, ypos});
    y_next = y_cur;
    if (up && !down) begin
      y_next = y_cur - SPEED;
    end else if (down && !up) begin
      y_next = y_cur + SPEED;
    end
    if (y_next < 11'sd0) begin
      y_next = 11'sd0;
    end else if (y_next > Y_MAX) begin
      y_next = Y_MAX;
    end
  end

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      ypos <= Y_RST;
    end else if (step) begin
      ypos <= y_next[9:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_game_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_game_core                                                           |
// | Frame-stepped Pong game engine: ball motion and collisions, scores,     |
// | serve delay with blinking ball, and the IDLE/SERVE/PLAY/OVER FSM.        |
// | Inputs : clk_0, rst (async, active-high), frame_tick, start,            |
// |          up_p1, down_p1, up_p2, down_p2                                  |
// | Outputs: sq_xpos/sq_ypos (ball), pdl1_*/pdl2_* (paddles), sq_shown,      |
// |          score_p1, score_p2, game_state, winner                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pong_game_core
  import pong_pkg::*;
#(
  parameter int H_RES         = DEF_H_RES,
  parameter int V_RES         = DEF_V_RES,
  parameter int BALL_SIZE     = DEF_BALL_SIZE,
  parameter int PADDLE_W      = DEF_PADDLE_W,
  parameter int PADDLE_H      = DEF_PADDLE_H,
  parameter int PADDLE_MARGIN = DEF_PADDLE_MARGIN,
  parameter int PADDLE_SPEED  = DEF_PADDLE_SPEED,
  parameter int BALL_SPEED    = DEF_BALL_SPEED,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES  = DEF_SERVE_FRAMES
)(
  input  logic               clk_0,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               up_p1,
  input  logic               down_p1,
  input  logic               up_p2,
  input  logic               down_p2,
  output logic [9:0]         sq_xpos,
  output logic [9:0]         sq_ypos,
  output logic [9:0]         pdl1_xpos,
  output logic [9:0]         pdl1_ypos,
  output logic [9:0]         pdl2_xpos,
  output logic [9:0]         pdl2_ypos,
  output logic               sq_shown,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         game_state,
  output logic               winner
);

  // Counter is at least 4 bits so its bit 3 can drive the serve blink.
  localparam int CNT_W = ($clog2(SERVE_FRAMES) < 4) ? 4 : $clog2(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_LAST   = SCORE_W'(WIN_SCORE - 1);

  localparam logic [9:0] BALL_X0 = 10'(centre(H_RES, BALL_SIZE));
  localparam logic [9:0] BALL_Y0 = 10'(centre(V_RES, BALL_SIZE));
  localparam logic [9:0] P1_X    = 10'(PADDLE_MARGIN);
  localparam logic [9:0] P2_X    = 10'(H_RES - PADDLE_MARGIN - PADDLE_W);

  localparam logic signed [10:0] S_SPEED = 11'(BALL_SPEED);
  localparam logic signed [10:0] S_BALL  = 11'(BALL_SIZE);
  localparam logic signed [10:0] S_PW    = 11'(PADDLE_W);
  localparam logic signed [10:0] S_PH    = 11'(PADDLE_H);
  localparam logic signed [10:0] S_XMAX  = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] S_YMAX  = 11'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] S_P1X   = 11'(PADDLE_MARGIN);
  localparam logic signed [10:0] S_P2X   = 11'(H_RES - PADDLE_MARGIN - PADDLE_W);

  game_state_t      state;
  logic [9:0]       ball_x;
  logic [9:0]       ball_y;
  logic             dx_neg;
  logic             dy_neg;
  logic [CNT_W-1:0] serve_cnt;
  logic [CNT_W-1:0] serve_cnt_inc;
  logic             paddle_step;

  logic signed [10:0] cur_x, cur_y, p1_y, p2_y, nx, ny;
  logic               ndx_neg, ndy_neg, p1_scores, p2_scores;

  assign paddle_step   = frame_tick && (state == ST_SERVE || state == ST_PLAY);
  assign serve_cnt_inc = serve_cnt + 1'b1;

  pong_paddle #(
    .V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
  ) u_paddle_p1 (
    .clk_0(clk_0), .rst(rst), .step(paddle_step),
    .up(up_p1), .down(down_p1), .ypos(pdl1_ypos)
  );

  pong_paddle #(
    .V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
  ) u_paddle_p2 (
    .clk_0(clk_0), .rst(rst), .step(paddle_step),
    .up(up_p2), .down(down_p2), .ypos(pdl2_ypos)
  );

  // Candidate ball step. Wall clamp first, then paddle hits are tested on
  // the wall-corrected y, then the miss test on the paddle-corrected x.
  // Collisions use the paddle positions from before this frame's move.
  always_comb begin
    cur_x   = signed'({1'b0, ball_x});
    cur_y   = signed'({1'b0, ball_y});
    p1_y    = signed'({1'b0, pdl1_ypos});
    p2_y    = signed'({1'b0, pdl2_ypos});
    nx      = dx_neg ? cur_x - S_SPEED : cur_x + S_SPEED;
    ny      = dy_neg ? cur_y - S_SPEED : cur_y + S_SPEED;
    ndx_neg = dx_neg;
    ndy_neg = dy_neg;

    if (ny < 11'sd0) begin
      ny      = 11'sd0;
      ndy_neg = ~dy_neg;
    end else if (ny > S_YMAX) begin
      ny      = S_YMAX;
      ndy_neg = ~dy_neg;
    end

    if (dx_neg && (nx <= S_P1X + S_PW) && (nx + S_BALL > S_P1X) &&
        (ny < p1_y + S_PH) && (ny + S_BALL > p1_y)) begin
      nx      = S_P1X + S_PW;
      ndx_neg = 1'b0;
    end else if (!dx_neg && (nx + S_BALL >= S_P2X) && (nx < S_P2X + S_PW) &&
                 (ny < p2_y + S_PH) && (ny + S_BALL > p2_y)) begin
      nx      = S_P2X - S_BALL;
      ndx_neg = 1'b1;
    end

    p2_scores = (nx <= 11'sd0);
    p1_scores = (nx >= S_XMAX);
  end

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      serve_cnt <= '0;
      score_p1  <= '0;
      score_p2  <= '0;
      winner    <= 1'b0;
      sq_shown  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state     <= ST_SERVE;
            score_p1  <= '0;
            score_p2  <= '0;
            serve_cnt <= '0;
            dx_neg    <= 1'b0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            sq_shown  <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              state    <= ST_PLAY;
              sq_shown <= 1'b1;
            end else begin
              serve_cnt <= serve_cnt_inc;
              sq_shown  <= serve_cnt_inc[3];
            end
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            dy_neg <= ndy_neg;
            if (p1_scores || p2_scores) begin
              ball_x    <= BALL_X0;
              ball_y    <= BALL_Y0;
              serve_cnt <= '0;
              sq_shown  <= 1'b0;
              // Next serve heads toward whoever conceded (P1 is on the left).
              dx_neg    <= p2_scores;
              if (p2_scores) begin
                score_p2 <= score_p2 + 1'b1;
                if (score_p2 == WIN_LAST) begin
                  state  <= ST_OVER;
                  winner <= 1'b1;
                end else begin
                  state <= ST_SERVE;
                end
              end else begin
                score_p1 <= score_p1 + 1'b1;
                if (score_p1 == WIN_LAST) begin
                  state  <= ST_OVER;
                  winner <= 1'b0;
                end else begin
                  state <= ST_SERVE;
                end
              end
            end else begin
              ball_x <= nx[9:0];
              ball_y <= ny[9:0];
              dx_neg <= ndx_neg;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sq_xpos    = ball_x;
  assign sq_ypos    = ball_y;
  assign pdl1_xpos  = P1_X;
  assign pdl2_xpos  = P2_X;
  assign game_state = state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pong_game_core                                                        |
// | Randomised self-checking bench for pong_game_core. A game model written |
// | with plain integer arithmetic tracks the expected state and is compared |
// | against the DUT on every falling clock edge; a few literal checks pin   |
// | the model to known values (reset, serve timing, clamps, game over).     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pong_game_core;

  localparam int H = 640, V = 480, B = 8, PW = 8, PH = 64, MG = 16;
  localparam int PS = 4, BS = 2, WIN = 9, SF = 60;
  localparam int P1X = MG, P2X = H - MG - PW;
  localparam int CX = (H - B) / 2, CY = (V - B) / 2, PY0 = (V - PH) / 2;

  logic clk_0 = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0, start = 1'b0;
  logic up_p1 = 1'b0, down_p1 = 1'b0, up_p2 = 1'b0, down_p2 = 1'b0;
  logic [9:0] sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos;
  logic       sq_shown, winner;
  logic [3:0] score_p1, score_p2;
  logic [1:0] game_state;

  pong_game_core dut (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .start(start),
    .up_p1(up_p1), .down_p1(down_p1), .up_p2(up_p2), .down_p2(down_p2),
    .sq_xpos(sq_xpos), .sq_ypos(sq_ypos),
    .pdl1_xpos(pdl1_xpos), .pdl1_ypos(pdl1_ypos),
    .pdl2_xpos(pdl2_xpos), .pdl2_ypos(pdl2_ypos),
    .sq_shown(sq_shown), .score_p1(score_p1), .score_p2(score_p2),
    .game_state(game_state), .winner(winner)
  );

  always #5 clk_0 = ~clk_0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  // m_st: 0 idle, 1 serve, 2 play, 3 over; m_dx/m_dy are +1 / -1.
  int m_st, m_s1, m_s2, m_win, m_bx, m_by, m_dx, m_dy, m_p1y, m_p2y, m_cnt;
  int overs = 0;
  bit model_live = 0;

  function automatic int pad_move(input int y, input bit u, input bit d);
    int r;
    r = y;
    if (u && !d) r = y - PS;
    else if (d && !u) r = y + PS;
    if (r < 0) r = 0;
    if (r > V - PH) r = V - PH;
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
    m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
    m_p1y = PY0; m_p2y = PY0; m_cnt = 0;
  endtask

  task automatic ball_step();
    int nx, ny;
    bit p2pt;
    nx = m_bx + m_dx * BS;
    ny = m_by + m_dy * BS;
    if (ny < 0) begin ny = 0; m_dy = -m_dy; end
    else if (ny > V - B) begin ny = V - B; m_dy = -m_dy; end
    if (m_dx < 0 && nx <= P1X + PW && nx + B > P1X && ny < m_p1y + PH && ny + B > m_p1y) begin
      nx = P1X + PW; m_dx = 1;
    end else if (m_dx > 0 && nx + B >= P2X && nx < P2X + PW && ny < m_p2y + PH && ny + B > m_p2y) begin
      nx = P2X - B; m_dx = -1;
    end
    if (nx <= 0 || nx >= H - B) begin
      p2pt = (nx <= 0);
      if (p2pt) m_s2++; else m_s1++;
      m_dx = p2pt ? -1 : 1;
      m_bx = CX; m_by = CY; m_cnt = 0;
      if ((p2pt ? m_s2 : m_s1) == WIN) begin m_st = 3; m_win = p2pt; overs++; end
      else m_st = 1;
    end else begin
      m_bx = nx; m_by = ny;
    end
  endtask

  task automatic model_step();
    if (m_st == 0 || m_st == 3) begin
      if (start) begin
        m_st = 1; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_dx = 1; m_bx = CX; m_by = CY;
      end
    end else if (frame_tick) begin
      if (m_st == 2) ball_step();
      else if (m_cnt == SF - 1) m_st = 2;
      else m_cnt++;
      m_p1y = pad_move(m_p1y, up_p1, down_p1);
      m_p2y = pad_move(m_p2y, up_p2, down_p2);
    end
  endtask

  initial forever begin
    @(posedge clk_0 or posedge rst);
    if (rst) begin model_reset(); model_live = 1; end
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk_0);
    if (model_live && !rst) begin
      check("state", game_state, m_st);
      check("ball_x", sq_xpos, m_bx);
      check("ball_y", sq_ypos, m_by);
      check("pdl1_x", pdl1_xpos, P1X);
      check("pdl2_x", pdl2_xpos, P2X);
      check("pdl1_y", pdl1_ypos, m_p1y);
      check("pdl2_y", pdl2_ypos, m_p2y);
      check("score_p1", score_p1, m_s1);
      check("score_p2", score_p2, m_s2);
      check("shown", sq_shown, (m_st == 1) ? ((m_cnt >> 3) & 1) : ((m_st == 2) ? 1 : 0));
      if (m_st == 3) check("winner", winner, m_win);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit t, input bit s, input bit u1, input bit d1, input bit u2, input bit d2);
    @(negedge clk_0);
    #1;
    frame_tick = t; start = s;
    up_p1 = u1; down_p1 = d1; up_p2 = u2; down_p2 = d2;
  endtask

  // One tick followed by 1..3 quiet cycles; on return every input already
  // applied has been sampled, so the model reflects the DUT state.
  task automatic tick_cycle(input bit s, input bit u1, input bit d1, input bit u2, input bit d2);
    int gap;
    gap = $urandom_range(1, 3);
    drive(1'b1, s, u1, d1, u2, d2);
    repeat (gap) drive(1'b0, 1'b0, u1, d1, u2, d2);
  endtask

  task automatic reset_literals(input string tag);
    check({tag, "_ball_x"}, sq_xpos, 316);
    check({tag, "_ball_y"}, sq_ypos, 236);
    check({tag, "_pdl1_y"}, pdl1_ypos, 208);
    check({tag, "_pdl2_y"}, pdl2_ypos, 208);
    check({tag, "_pdl1_x"}, pdl1_xpos, 16);
    check({tag, "_pdl2_x"}, pdl2_xpos, 616);
    check({tag, "_state"}, game_state, 0);
    check({tag, "_shown"}, sq_shown, 0);
    check({tag, "_scores"}, {score_p1, score_p2}, 0);
  endtask

  int ticks, mode, len, n;
  bit b_u1, b_d1, b_u2, b_d2, st, over_checked;

  initial begin
    over_checked = 0;
    repeat (3) @(negedge clk_0);
    reset_literals("rst_init");
    check("rst_init_winner", winner, 0);
    #1 rst = 1'b0;

    // Paddles are frozen in IDLE.
    repeat (5) tick_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("idle_pdl1_frozen", pdl1_ypos, 208);

    // Start, then a 60-tick serve holding P1 up and both P2 buttons.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("serve_entry", game_state, 1);
    for (int k = 1; k <= 60; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      if (k == 7)  check("blink_k7", sq_shown, 0);
      if (k == 8)  check("blink_k8", sq_shown, 1);
      if (k == 16) check("blink_k16", sq_shown, 0);
      if (k == 59) check("serve_k59", game_state, 1);
      if (k == 60) begin
        check("play_k60", game_state, 2);
        check("shown_k60", sq_shown, 1);
        check("pdl1_clamp0", pdl1_ypos, 0);
        check("pdl2_both_held", pdl2_ypos, 208);
      end
    end

    // Randomised play until two games have been won.
    ticks = 0;
    while (overs < 2 && ticks < 15000) begin
      mode = $urandom_range(0, 5);
      len  = $urandom_range(20, 150);
      b_u1 = 1'($urandom_range(0, 1)); b_d1 = 1'($urandom_range(0, 1));
      b_u2 = 1'($urandom_range(0, 1)); b_d2 = 1'($urandom_range(0, 1));
      for (int i = 0; i < len && overs < 2; i++) begin
        if (mode <= 2) begin
          b_u1 = 1'($urandom_range(0, 1)); b_d1 = 1'($urandom_range(0, 1));
          b_u2 = 1'($urandom_range(0, 1)); b_d2 = 1'($urandom_range(0, 1));
        end else if (mode >= 4) begin
          b_u1 = (m_p1y + PH / 2 > m_by + B / 2 + 2);
          b_d1 = (m_p1y + PH / 2 < m_by + B / 2 - 2);
          if (mode == 5) begin
            b_u2 = (m_p2y + PH / 2 > m_by + B / 2 + 2);
            b_d2 = (m_p2y + PH / 2 < m_by + B / 2 - 2);
          end
        end
        if (m_st == 0 || m_st == 3) st = ($urandom_range(0, 3) == 0);
        else st = ($urandom_range(0, 7) == 0);
        if (m_st == 3 && !over_checked) st = 1'b0;
        tick_cycle(st, b_u1, b_d1, b_u2, b_d2);
        ticks++;
        if (m_st == 3 && !over_checked) begin
          over_checked = 1;
          drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
          drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          check("over_state", game_state, 3);
          check("over_shown", sq_shown, 0);
          check("over_winner", winner, (m_s2 == WIN) ? 1 : 0);
          check("over_win_score", (m_s1 == WIN || m_s2 == WIN) ? 1 : 0, 1);
          drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          check("restart_state", game_state, 1);
          check("restart_scores", {score_p1, score_p2}, 0);
        end
      end
    end
    check("two_games_completed", (overs >= 2) ? 1 : 0, 1);

    // Get back into PLAY, then pulse reset between clock edges.
    n = 0;
    while (m_st != 2 && n < 300) begin
      tick_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    check("reach_play_before_reset", m_st, 2);
    @(negedge clk_0);
    #2 rst = 1'b1;
    #1 reset_literals("rst_async");
    @(negedge clk_0);
    #1 rst = 1'b0;

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) tick_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
